// File: rtl/tl_dma_copy_pkg.sv
// Shared encodings for the TileLink block copy engine.
// Holds the TL A/D opcode encodings and the copy engine state enum.
package tl_dma_copy_pkg;

    localparam int unsigned TlSizeWidth = 4;

    typedef enum logic [2:0] {
        TL_A_PUT_FULL_DATA    = 3'd0,
        TL_A_PUT_PARTIAL_DATA = 3'd1,
        TL_A_ARITHMETIC_DATA  = 3'd2,
        TL_A_LOGICAL_DATA     = 3'd3,
        TL_A_GET              = 3'd4,
        TL_A_INTENT           = 3'd5,
        TL_A_ACQUIRE_BLOCK    = 3'd6,
        TL_A_ACQUIRE_PERM     = 3'd7
    } tl_a_op_e;

    typedef enum logic [2:0] {
        TL_D_ACCESS_ACK      = 3'd0,
        TL_D_ACCESS_ACK_DATA = 3'd1,
        TL_D_HINT_ACK        = 3'd2,
        TL_D_GRANT           = 3'd4,
        TL_D_GRANT_DATA      = 3'd5,
        TL_D_RELEASE_ACK     = 3'd6
    } tl_d_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET,
        ST_RDATA,
        ST_PUT,
        ST_WACK,
        ST_DONE
    } dma_state_e;

endpackage

// File: rtl/tl_dma_copy.sv
// Memory-to-memory block copy engine, TileLink host on the DMA port.
// Each block: one Get burst into a local beat buffer, then one PutFullData
// burst out of it. Completion and error are reported on a one-cycle pulse.
// Ports:
//   clk_i / rst_ni               clock, async active-low reset
//   cmd_*                        command (src, dst, length in blocks) + ready
//   busy_o / done_o / error_o    status
//   a_* / b_* / c_* / d_* / e_*  TL-C host channels (B, C, E idle)
module tl_dma_copy
    import tl_dma_copy_pkg::*;
#(
    parameter int unsigned DataWidth   = 128,
    parameter int unsigned AddrWidth   = 38,
    parameter int unsigned SourceWidth = 3,
    parameter int unsigned SinkWidth   = 4,
    parameter int unsigned BlockSize   = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [AddrWidth-1:0]     cmd_src_i,
    input  logic [AddrWidth-1:0]     cmd_dst_i,
    input  logic [31:0]              cmd_len_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic                     a_valid_o,
    input  logic                     a_ready_i,
    output logic [2:0]               a_opcode_o,
    output logic [2:0]               a_param_o,
    output logic [TlSizeWidth-1:0]   a_size_o,
    output logic [SourceWidth-1:0]   a_source_o,
    output logic [AddrWidth-1:0]     a_address_o,
    output logic [DataWidth/8-1:0]   a_mask_o,
    output logic [DataWidth-1:0]     a_data_o,
    output logic                     a_corrupt_o,
    input  logic                     b_valid_i,
    output logic                     b_ready_o,
    input  logic [2:0]               b_opcode_i,
    input  logic [1:0]               b_param_i,
    input  logic [TlSizeWidth-1:0]   b_size_i,
    input  logic [SourceWidth-1:0]   b_source_i,
    input  logic [AddrWidth-1:0]     b_address_i,
    input  logic [DataWidth/8-1:0]   b_mask_i,
    input  logic [DataWidth-1:0]     b_data_i,
    input  logic                     b_corrupt_i,
    output logic                     c_valid_o,
    input  logic                     c_ready_i,
    output logic [2:0]               c_opcode_o,
    output logic [2:0]               c_param_o,
    output logic [TlSizeWidth-1:0]   c_size_o,
    output logic [SourceWidth-1:0]   c_source_o,
    output logic [AddrWidth-1:0]     c_address_o,
    output logic [DataWidth-1:0]     c_data_o,
    output logic                     c_corrupt_o,
    input  logic                     d_valid_i,
    output logic                     d_ready_o,
    input  logic [2:0]               d_opcode_i,
    input  logic [1:0]               d_param_i,
    input  logic [TlSizeWidth-1:0]   d_size_i,
    input  logic [SourceWidth-1:0]   d_source_i,
    input  logic [SinkWidth-1:0]     d_sink_i,
    input  logic                     d_denied_i,
    input  logic [DataWidth-1:0]     d_data_i,
    input  logic                     d_corrupt_i,
    output logic                     e_valid_o,
    input  logic                     e_ready_i,
    output logic [SinkWidth-1:0]     e_sink_o
);

    localparam int unsigned BlockBytes = 32'd1 << BlockSize;
    localparam int unsigned Beats      = (BlockBytes * 8) / DataWidth;
    localparam int unsigned BeatW      = (Beats > 1) ? $clog2(Beats) : 1;

    dma_state_e                 r_state;
    logic [AddrWidth-1:0]       r_src;
    logic [AddrWidth-1:0]       r_dst;
    logic [31:0]                r_len;
    logic                       r_err;
    logic [BeatW-1:0]           r_beat;
    logic [DataWidth-1:0]       r_buf [Beats];
    logic                       r_cmd_ready;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_error;
    logic                       r_a_valid;
    logic [2:0]                 r_a_opcode;
    logic [AddrWidth-1:0]       r_a_address;
    logic [DataWidth-1:0]       r_a_data;
    logic                       r_d_ready;

    logic [AddrWidth-1:0]       w_src_aligned;
    logic [AddrWidth-1:0]       w_dst_aligned;
    logic [AddrWidth-1:0]       w_src_next;
    logic [AddrWidth-1:0]       w_dst_next;
    logic                       w_beat_last;
    logic [BeatW-1:0]           w_beat_inc;
    logic                       w_err_rd;
    logic                       w_err_wr;
    logic [DataWidth-1:0]       w_put_first;
    logic                       w_unused_tl;

    assign w_src_aligned = {cmd_src_i[AddrWidth-1:BlockSize], {BlockSize{1'b0}}};
    assign w_dst_aligned = {cmd_dst_i[AddrWidth-1:BlockSize], {BlockSize{1'b0}}};
    assign w_src_next    = r_src + AddrWidth'(BlockBytes);
    assign w_dst_next    = r_dst + AddrWidth'(BlockBytes);
    assign w_beat_last   = (r_beat == BeatW'(Beats - 1));
    assign w_beat_inc    = r_beat + BeatW'(1);

    // Error flag as it stands after the current D beat is accepted.
    assign w_err_rd = r_err | d_denied_i | d_corrupt_i | (d_opcode_i != TL_D_ACCESS_ACK_DATA);
    assign w_err_wr = r_err | d_denied_i | (d_opcode_i != TL_D_ACCESS_ACK);

    // With a single-beat block, slot 0 is being filled in the same cycle.
    assign w_put_first = (Beats == 1) ? d_data_i : r_buf[0];

    // Fixed A attributes; B, C and E channels are never used.
    assign a_param_o   = '0;
    assign a_size_o    = TlSizeWidth'(BlockSize);
    assign a_source_o  = '0;
    assign a_mask_o    = '1;
    assign a_corrupt_o = 1'b0;
    assign b_ready_o   = 1'b1;
    assign c_valid_o   = 1'b0;
    assign c_opcode_o  = '0;
    assign c_param_o   = '0;
    assign c_size_o    = '0;
    assign c_source_o  = '0;
    assign c_address_o = '0;
    assign c_data_o    = '0;
    assign c_corrupt_o = 1'b0;
    assign e_valid_o   = 1'b0;
    assign e_sink_o    = '0;

    assign w_unused_tl = ^{b_valid_i, b_opcode_i, b_param_i, b_size_i, b_source_i, b_address_i,
                           b_mask_i, b_data_i, b_corrupt_i, c_ready_i, e_ready_i,
                           d_param_i, d_size_i, d_source_i, d_sink_i};

    assign cmd_ready_o = r_cmd_ready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign error_o     = r_error;
    assign a_valid_o   = r_a_valid;
    assign a_opcode_o  = r_a_opcode;
    assign a_address_o = r_a_address;
    assign a_data_o    = r_a_data;
    assign d_ready_o   = r_d_ready;

    // Copy sequencer; every output is loaded together with its next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_err       <= 1'b0;
            r_beat      <= '0;
            r_buf       <= '{default: '0};
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_a_valid   <= 1'b0;
            r_a_opcode  <= TL_A_GET;
            r_a_address <= '0;
            r_a_data    <= '0;
            r_d_ready   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (cmd_valid_i && r_cmd_ready) begin
                        r_src       <= w_src_aligned;
                        r_dst       <= w_dst_aligned;
                        r_len       <= cmd_len_i;
                        r_err       <= 1'b0;
                        r_beat      <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (cmd_len_i == 32'd0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_error <= 1'b0;
                        end else begin
                            r_state     <= ST_GET;
                            r_a_valid   <= 1'b1;
                            r_a_opcode  <= TL_A_GET;
                            r_a_address <= w_src_aligned;
                        end
                    end
                end
                ST_GET: begin
                    if (a_ready_i) begin
                        r_a_valid <= 1'b0;
                        r_d_ready <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    // All beats are drained even after an error is seen.
                    if (d_valid_i) begin
                        r_buf[r_beat] <= d_data_i;
                        r_err         <= w_err_rd;
                        if (w_beat_last) begin
                            r_d_ready <= 1'b0;
                            r_beat    <= '0;
                            if (w_err_rd) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                                r_error <= 1'b1;
                            end else begin
                                r_state     <= ST_PUT;
                                r_a_valid   <= 1'b1;
                                r_a_opcode  <= TL_A_PUT_FULL_DATA;
                                r_a_address <= r_dst;
                                r_a_data    <= w_put_first;
                            end
                        end else begin
                            r_beat <= w_beat_inc;
                        end
                    end
                end
                ST_PUT: begin
                    if (a_ready_i) begin
                        if (w_beat_last) begin
                            r_a_valid <= 1'b0;
                            r_d_ready <= 1'b1;
                            r_beat    <= '0;
                            r_state   <= ST_WACK;
                        end else begin
                            r_beat   <= w_beat_inc;
                            r_a_data <= r_buf[w_beat_inc];
                        end
                    end
                end
                ST_WACK: begin
                    if (d_valid_i) begin
                        r_d_ready <= 1'b0;
                        r_err     <= w_err_wr;
                        r_src     <= w_src_next;
                        r_dst     <= w_dst_next;
                        r_len     <= r_len - 32'd1;
                        if (w_err_wr || (r_len == 32'd1)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_error <= w_err_wr;
                        end else begin
                            r_state     <= ST_GET;
                            r_a_valid   <= 1'b1;
                            r_a_opcode  <= TL_A_GET;
                            r_a_address <= w_src_next;
                        end
                    end
                end
                ST_DONE: begin
                    r_done      <= 1'b0;
                    r_error     <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tl_dma_copy.sv
// Bench for tl_dma_copy: a TL memory model answers the host port, an
// expected-transaction queue built from the command describes every A beat,
// and directed copies cover alignment, wrap, stalls, errors and reset.
module tb_tl_dma_copy;
    import tl_dma_copy_pkg::*;

    localparam int unsigned DW    = 128;
    localparam int unsigned AW    = 38;
    localparam int unsigned SW    = 3;
    localparam int unsigned KW    = 4;
    localparam int unsigned BS    = 6;
    localparam int unsigned BEATS = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            cmd_valid_i = 1'b0;
    logic            cmd_ready_o;
    logic [AW-1:0]   cmd_src_i = '0;
    logic [AW-1:0]   cmd_dst_i = '0;
    logic [31:0]     cmd_len_i = '0;
    logic            busy_o, done_o, error_o;
    logic            a_valid_o;
    logic            a_ready_i = 1'b0;
    logic [2:0]      a_opcode_o, a_param_o;
    logic [3:0]      a_size_o;
    logic [SW-1:0]   a_source_o;
    logic [AW-1:0]   a_address_o;
    logic [DW/8-1:0] a_mask_o;
    logic [DW-1:0]   a_data_o;
    logic            a_corrupt_o;
    logic            b_ready_o;
    logic            c_valid_o;
    logic [2:0]      c_opcode_o, c_param_o;
    logic [3:0]      c_size_o;
    logic [SW-1:0]   c_source_o;
    logic [AW-1:0]   c_address_o;
    logic [DW-1:0]   c_data_o;
    logic            c_corrupt_o;
    logic            d_valid_i = 1'b0;
    logic            d_ready_o;
    logic [2:0]      d_opcode_i = '0;
    logic            d_denied_i = 1'b0;
    logic [DW-1:0]   d_data_i = '0;
    logic            e_valid_o;
    logic [KW-1:0]   e_sink_o;

    always #5 clk_i = ~clk_i;

    tl_dma_copy dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_src_i(cmd_src_i), .cmd_dst_i(cmd_dst_i), .cmd_len_i(cmd_len_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .a_valid_o(a_valid_o), .a_ready_i(a_ready_i), .a_opcode_o(a_opcode_o),
        .a_param_o(a_param_o), .a_size_o(a_size_o), .a_source_o(a_source_o),
        .a_address_o(a_address_o), .a_mask_o(a_mask_o), .a_data_o(a_data_o),
        .a_corrupt_o(a_corrupt_o),
        .b_valid_i(1'b0), .b_ready_o(b_ready_o), .b_opcode_i(3'd0), .b_param_i(2'd0),
        .b_size_i(4'd0), .b_source_i('0), .b_address_i('0), .b_mask_i('0),
        .b_data_i('0), .b_corrupt_i(1'b0),
        .c_valid_o(c_valid_o), .c_ready_i(1'b1), .c_opcode_o(c_opcode_o),
        .c_param_o(c_param_o), .c_size_o(c_size_o), .c_source_o(c_source_o),
        .c_address_o(c_address_o), .c_data_o(c_data_o), .c_corrupt_o(c_corrupt_o),
        .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_opcode_i(d_opcode_i),
        .d_param_i(2'd0), .d_size_i(4'(BS)), .d_source_i('0), .d_sink_i('0),
        .d_denied_i(d_denied_i), .d_data_i(d_data_i), .d_corrupt_i(1'b0),
        .e_valid_o(e_valid_o), .e_ready_i(1'b1), .e_sink_o(e_sink_o)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Source memory content that was never written is this address pattern.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [31:0] w;
        w = a[35:4];
        return {w ^ 32'hA5A5_5A5A, ~w, w + 32'h1357_9BDF, {a[37:36], 30'h2AAA_AAAA} ^ w};
    endfunction

    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } a_exp_t;

    typedef struct {
        logic [2:0]    op;
        logic          denied;
        logic [DW-1:0] data;
    } d_beat_t;

    a_exp_t        exp_q[$];
    d_beat_t       d_q[$];
    logic [AW-1:0] get_log[$];
    logic [AW-1:0] put_log[$];
    bit            stall = 0;
    int            get_cnt = 0;
    int            put_cnt = 0;
    int            inj_get = -1;
    int            inj_beat = -1;

    // Every block of a copy is one Get of the source then Beats Put beats of
    // the same bytes to the destination; addresses wrap at AW bits.
    task automatic push_model(input logic [AW-1:0] s, input logic [AW-1:0] d, input int len);
        logic [AW-1:0] sa, da;
        sa = s & ~AW'(63);
        da = d & ~AW'(63);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{3'd4, sa, '0});
            for (int b = 0; b < BEATS; b++)
                exp_q.push_back('{3'd0, da, pat(sa + AW'(16 * b))});
            sa = sa + AW'(64);
            da = da + AW'(64);
        end
    endtask

    // Fabric + compare process: decides a_ready/D beats for the coming edge
    // and checks each A beat that will be accepted on it.
    bit            d_fire = 0;
    bit            a_hold = 0;
    int            put_beats = 0;
    logic [AW-1:0] put_addr;
    logic [2:0]    h_op;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;

    always @(negedge clk_i) begin
        d_beat_t db;
        a_exp_t  e;
        if (!rst_ni) begin
            exp_q.delete();
            d_q.delete();
            a_ready_i = 1'b0;
            d_valid_i = 1'b0;
            d_fire    = 0;
            a_hold    = 0;
            put_beats = 0;
        end else begin
            check("busy_vs_ready", busy_o, !cmd_ready_o);
            check("a_d_exclusive", a_valid_o & d_ready_o, 0);
            if (d_fire) begin
                d_valid_i = 1'b0;
                d_fire    = 0;
            end
            if (!d_valid_i && d_q.size() > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
                db = d_q.pop_front();
                d_valid_i  = 1'b1;
                d_opcode_i = db.op;
                d_denied_i = db.denied;
                d_data_i   = db.data;
            end
            if (d_valid_i && d_ready_o) d_fire = 1;

            if (a_hold)
                check("a_stable_stalled", {a_valid_o, a_opcode_o, a_address_o, a_data_o},
                      {1'b1, h_op, h_addr, h_data});
            a_ready_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            a_hold = a_valid_o && !a_ready_i;
            h_op   = a_opcode_o;
            h_addr = a_address_o;
            h_data = a_data_o;
            if (a_valid_o && a_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_a: got op %0d addr %0h, required no A beat",
                             a_opcode_o, a_address_o);
                end else begin
                    e = exp_q.pop_front();
                    check("a_opcode", a_opcode_o, e.op);
                    check("a_address", a_address_o, e.addr);
                    check("a_attrs", {a_param_o, a_size_o, a_source_o, a_mask_o, a_corrupt_o},
                          {3'd0, 4'd6, 3'd0, 16'hFFFF, 1'b0});
                    if (e.op == 3'd0) check("put_data", a_data_o, e.data);
                end
                if (a_opcode_o == 3'd4) begin
                    get_log.push_back(a_address_o);
                    for (int b = 0; b < BEATS; b++)
                        d_q.push_back('{3'd1, (get_cnt == inj_get) && (b == inj_beat),
                                        mem_rd(a_address_o + AW'(16 * b))});
                    get_cnt++;
                end else begin
                    if (put_beats == 0) begin
                        put_addr = a_address_o;
                        put_log.push_back(a_address_o);
                    end
                    mem[put_addr + AW'(16 * put_beats)] = a_data_o;
                    put_beats++;
                    if (put_beats == BEATS) begin
                        put_beats = 0;
                        put_cnt++;
                        d_q.push_back('{3'd0, 1'b0, '0});
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        get_log.delete();
        put_log.delete();
        get_cnt = 0;
        put_cnt = 0;
    endtask

    // Issue a command from a negedge and wait for its done pulse.
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int len,
                            input logic exp_err, input int exp_cyc);
        int k;
        @(negedge clk_i);
        cmd_src_i = s;
        cmd_dst_i = d;
        cmd_len_i = len;
        cmd_valid_i = 1'b1;
        k = 0;
        while (!cmd_ready_o && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        check("cmd_accept", cmd_ready_o, 1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        k = 1;
        while (!done_o && k < 3000) begin
            @(negedge clk_i);
            k++;
        end
        check("done_seen", done_o, 1);
        check("error_o", error_o, exp_err);
        if (exp_cyc > 0) check("done_latency", k, exp_cyc);
        @(negedge clk_i);
        check("done_one_cycle", done_o, 0);
        check("model_drained", {exp_q.size(), d_q.size(), d_valid_i}, 0);
    endtask

    task automatic check_dst(input logic [AW-1:0] s, input logic [AW-1:0] d, input int len);
        for (int i = 0; i < len; i++)
            for (int b = 0; b < BEATS; b++)
                check("dst_equals_src", mem_rd(d + AW'(64 * i + 16 * b)),
                      pat(s + AW'(64 * i + 16 * b)));
    endtask

    initial begin
        int  k;
        bit  done_seen;
        repeat (3) @(negedge clk_i);
        check("reset_outputs", {cmd_ready_o, busy_o, done_o, error_o, a_valid_o, d_ready_o,
                                b_ready_o, c_valid_o, e_valid_o}, 9'b100000100);
        check("tieoff_ce", {c_opcode_o, c_param_o, c_size_o, c_source_o, c_address_o,
                            c_data_o, c_corrupt_o, e_sink_o}, 0);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;

        // Two-block copy, zero-wait fabric.
        clear_logs();
        push_model(38'h40_0000_0000 >> 4, 38'h40_0000_1000 >> 4, 0);
        push_model(38'h4000_0000, 38'h4000_1000, 2);
        run_copy(38'h4000_0000, 38'h4000_1000, 2, 1'b0, 21);
        check("get0_addr", get_log[0], 38'h4000_0000);
        check("get1_addr", get_log[1], 38'h4000_0040);
        check("put0_addr", put_log[0], 38'h4000_1000);
        check("put1_addr", put_log[1], 38'h4000_1040);
        check("txn_counts", {get_cnt, put_cnt}, {32'd2, 32'd2});
        check_dst(38'h4000_0000, 38'h4000_1000, 2);

        // Zero-length command: no A traffic, done right after acceptance.
        clear_logs();
        run_copy(38'h4000_5000, 38'h4000_6000, 0, 1'b0, 1);
        check("len0_no_traffic", {get_log.size(), put_log.size()}, 0);

        // Unaligned source is issued at the block boundary.
        clear_logs();
        push_model(38'h4000_2007, 38'h4000_3000, 1);
        run_copy(38'h4000_2007, 38'h4000_3000, 1, 1'b0, 11);
        check("unaligned_get_addr", get_log[0], 38'h4000_2000);
        check_dst(38'h4000_2000, 38'h4000_3000, 1);

        // Address wrap at the top of the space.
        clear_logs();
        push_model(38'h3F_FFFF_FFC0, 38'h00_0010_0000, 2);
        run_copy(38'h3F_FFFF_FFC0, 38'h00_0010_0000, 2, 1'b0, 21);
        check("wrap_get1_addr", get_log[1], 38'h0);
        check_dst(38'h3F_FFFF_FFC0, 38'h00_0010_0000, 2);

        // Random a_ready and D stalls.
        clear_logs();
        stall = 1;
        push_model(38'h4100_0000, 38'h4200_0000, 3);
        run_copy(38'h4100_0000, 38'h4200_0000, 3, 1'b0, 0);
        check_dst(38'h4100_0000, 38'h4200_0000, 3);
        stall = 0;

        // Denied on the second read beat of block 0: drain, no Put, error.
        clear_logs();
        inj_get = 0;
        inj_beat = 1;
        exp_q.push_back('{3'd4, 38'h4300_0000, '0});
        run_copy(38'h4300_0000, 38'h4400_0000, 3, 1'b1, 0);
        check("denied_counts", {get_cnt, put_cnt}, {32'd1, 32'd0});
        inj_get = -1;
        inj_beat = -1;

        // Command held while busy is taken only after done.
        clear_logs();
        push_model(38'h4500_0000, 38'h4600_0000, 1);
        push_model(38'h4700_0000, 38'h4800_0000, 1);
        @(negedge clk_i);
        cmd_src_i = 38'h4500_0000;
        cmd_dst_i = 38'h4600_0000;
        cmd_len_i = 1;
        cmd_valid_i = 1'b1;
        @(negedge clk_i);
        cmd_src_i = 38'h4700_0000;
        cmd_dst_i = 38'h4800_0000;
        done_seen = 0;
        k = 0;
        while (k < 500) begin
            if (done_o) done_seen = 1;
            if (cmd_ready_o) break;
            @(negedge clk_i);
            k++;
        end
        check("held_cmd_after_done", {cmd_ready_o, done_seen}, 2'b11);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        k = 0;
        while (!done_o && k < 500) begin
            @(negedge clk_i);
            k++;
        end
        check("held_cmd_done", {done_o, error_o}, 2'b10);
        @(negedge clk_i);
        check("held_cmd_counts", {get_cnt, put_cnt, exp_q.size()}, {32'd2, 32'd2, 32'd0});
        check_dst(38'h4700_0000, 38'h4800_0000, 1);

        // Reset asserted during PUT returns outputs to reset values at once.
        clear_logs();
        push_model(38'h4900_0000, 38'h4A00_0000, 2);
        @(negedge clk_i);
        cmd_src_i = 38'h4900_0000;
        cmd_dst_i = 38'h4A00_0000;
        cmd_len_i = 2;
        cmd_valid_i = 1'b1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        k = 0;
        while (!(a_valid_o && a_opcode_o == 3'd0) && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        check("reached_put", {a_valid_o, a_opcode_o}, 4'b1000);
        #1 rst_ni = 1'b0;
        #1 check("reset_in_put", {cmd_ready_o, busy_o, done_o, error_o, a_valid_o, d_ready_o,
                                  b_ready_o, c_valid_o, e_valid_o}, 9'b100000100);
        @(negedge clk_i);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;

        // Engine recovers after reset.
        clear_logs();
        push_model(38'h4B00_0000, 38'h4C00_0000, 1);
        run_copy(38'h4B00_0000, 38'h4C00_0000, 1, 1'b0, 11);
        check_dst(38'h4B00_0000, 38'h4C00_0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got no finish, required finish within 100000 cycles");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
